// File: rtl/fadd_arbiter.sv
// Round-robin sharing of one pipelined single-precision adder among NREQ requesters.
// A tag pipeline follows each op through the adder and steers its result into a per-requester holding register.
module fadd_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [32*NREQ-1:0]   resp_c,
    output logic [31:0]          fadd_a,
    output logic [31:0]          fadd_b,
    input  logic [31:0]          fadd_c,
    output logic [31:0]          issue_count
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW  = 32;

    logic [IDW-1:0]  rr_ptr;
    logic [LAT-1:0]  tag_vld;
    logic [IDW-1:0]  tag_id [LAT];
    logic [NREQ-1:0] inflight;
    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] eligible;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;
    logic            cap_vld;
    logic [IDW-1:0]  cap_id;

    // Holding rst_n low masks eligibility so nothing is granted while in reset.
    always_comb begin
        busy     = inflight | resp_valid;
        eligible = req_valid & ~busy & {NREQ{rst_n}};
        cap_vld  = tag_vld[LAT-1];
        cap_id   = tag_id[LAT-1];
    end

    // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!gnt_vld && eligible[i] && (((32'(rr_ptr) + k) % NREQ) == i)) begin
                    gnt_vld = 1'b1;
                    gnt_id  = IDW'(i);
                end
            end
        end
    end

    // Grant strobes and adder operand mux; operands idle at zero when nothing is granted.
    always_comb begin
        req_ready = '0;
        fadd_a    = '0;
        fadd_b    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_vld && (gnt_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                fadd_a       = req_a[DW*i +: DW];
                fadd_b       = req_b[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            tag_vld     <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
            inflight    <= '0;
            resp_valid  <= '0;
            resp_c      <= '0;
            issue_count <= '0;
        end else begin
            if (gnt_vld) begin
                rr_ptr      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                issue_count <= issue_count + 32'd1;
            end

            // Tag pipeline shifts every cycle in lockstep with the adder.
            tag_vld[0] <= gnt_vld;
            tag_id[0]  <= gnt_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end

            // Busy excludes grant/capture/handshake collisions on the same requester.
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
                if (gnt_vld && (gnt_id == IDW'(i))) begin
                    inflight[i] <= 1'b1;
                end
                if (cap_vld && (cap_id == IDW'(i))) begin
                    resp_valid[i]         <= 1'b1;
                    resp_c[DW*i +: DW]    <= fadd_c;
                    inflight[i]           <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of grants, in-flight ops and held responses.
module tb_fadd_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [32*N-1:0]   resp_c;
    logic [31:0]       fadd_a;
    logic [31:0]       fadd_b;
    logic [31:0]       fadd_c;
    logic [31:0]       issue_count;

    always #5 clk = ~clk;

    fadd_arbiter #(.NREQ(N), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_c      (resp_c),
        .fadd_a      (fadd_a),
        .fadd_b      (fadd_b),
        .fadd_c      (fadd_c),
        .issue_count (issue_count)
    );

    // Stand-in adder: the arbiter only routes data, so exact IEEE math matters only for the directed cases.
    function automatic logic [31:0] fadd_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h7f80_0000 && b == 32'hff80_0000) return 32'h7fff_ffff;
        if (a == 32'h3f80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    logic [31:0] pa [LAT];
    logic [31:0] pb [LAT];
    always_ff @(posedge clk) begin
        pa[0] <= fadd_a;
        pb[0] <= fadd_b;
        for (int k = 1; k < int'(LAT); k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end
    assign fadd_c = fadd_fn(pa[LAT-1], pb[LAT-1]);

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } op_t;

    op_t         q[$];
    bit          m_inf [N];
    bit          m_rv  [N];
    logic [31:0] m_rc  [N];
    int          m_rr;
    logic [31:0] m_cnt;
    int          cyc;
    int          vectors;
    int          miscompares;

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < int'(N); i++) begin
            m_inf[i] = 1'b0;
            m_rv[i]  = 1'b0;
            m_rc[i]  = 32'h0;
        end
        m_rr  = 0;
        m_cnt = 32'h0;
    endtask

    function automatic int exp_grant();
        if (!rst_n) return -1;
        for (int k = 0; k < int'(N); k++) begin
            int i = (m_rr + k) % int'(N);
            if (req_valid[i] && !m_inf[i] && !m_rv[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs to the model, advance the model across the coming edge, land on the next negedge.
    task automatic step();
        int              g;
        logic [N-1:0]    er;
        logic [31:0]     ea;
        logic [31:0]     eb;
        logic [N-1:0]    erv;
        logic [32*N-1:0] erc;
        op_t             keep[$];
        #1;
        g  = exp_grant();
        er = '0;
        ea = 32'h0;
        eb = 32'h0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ea    = req_a[32*g +: 32];
            eb    = req_b[32*g +: 32];
        end
        for (int i = 0; i < int'(N); i++) begin
            erv[i]          = m_rv[i];
            erc[32*i +: 32] = m_rc[i];
        end
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("fadd_a", 128'(fadd_a), 128'(ea));
        chk("fadd_b", 128'(fadd_b), 128'(eb));
        chk("resp_valid", 128'(resp_valid), 128'(erv));
        chk("resp_c", 128'(resp_c), 128'(erc));
        chk("issue_count", 128'(issue_count), 128'(m_cnt));
        if (!rst_n) begin
            m_reset();
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (m_rv[i] && resp_ready[i]) m_rv[i] = 1'b0;
            end
            foreach (q[j]) begin
                if (q[j].due == cyc) begin
                    m_rc[q[j].id]  = q[j].res;
                    m_rv[q[j].id]  = 1'b1;
                    m_inf[q[j].id] = 1'b0;
                end else begin
                    keep.push_back(q[j]);
                end
            end
            q = keep;
            if (g >= 0) begin
                q.push_back('{g, fadd_fn(ea, eb), cyc + int'(LAT)});
                m_inf[g] = 1'b1;
                m_rr     = (g + 1) % int'(N);
                m_cnt    = m_cnt + 32'd1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = '1;
        repeat (LAT + 3) step();
    endtask

    initial begin
        logic [N-1:0] onehot;
        logic [31:0]  held;
        int           others;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        req_valid   = '1;
        resp_ready  = '1;
        req_a       = {$urandom, $urandom, $urandom, $urandom};
        req_b       = {$urandom, $urandom, $urandom, $urandom};
        m_reset();
        @(negedge clk);

        // Reset held with every requester asking.
        repeat (3) begin
            #1;
            chk("rst_req_ready", 128'(req_ready), 128'(0));
            chk("rst_resp_valid", 128'(resp_valid), 128'(0));
            chk("rst_issue_count", 128'(issue_count), 128'(0));
            step();
        end

        // Round-robin from release: 0,1,2,3 then 0 again once its response is accepted.
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_a  = {$urandom, $urandom, $urandom, $urandom};
            req_b  = {$urandom, $urandom, $urandom, $urandom};
            onehot = '0;
            onehot[k % int'(N)] = 1'b1;
            #1;
            chk("rr_grant", 128'(req_ready), 128'(onehot));
            if (k == 4) chk("rr_count4", 128'(issue_count), 128'(4));
            step();
        end
        drain();

        // Single op 1.0 + 2.0 on requester 0.
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3f80_0000;
        req_b[31:0] = 32'h4000_0000;
        #1;
        chk("single_fadd_a", 128'(fadd_a), 128'(32'h3f80_0000));
        step();
        req_valid = '0;
        step();
        #1;
        chk("single_resp_valid", 128'(resp_valid[0]), 128'(1));
        chk("single_resp_c", 128'(resp_c[31:0]), 128'(32'h4040_0000));
        step();
        #1;
        chk("single_cleared", 128'(resp_valid[0]), 128'(0));
        drain();

        // Backpressure on requester 2 while the others keep flowing.
        req_valid  = 4'b0100;
        req_a[95:64] = 32'h1234_0000;
        req_b[95:64] = 32'h0000_5678;
        held       = fadd_fn(32'h1234_0000, 32'h0000_5678);
        resp_ready = 4'b1011;
        step();
        req_valid = '0;
        step();
        others = 0;
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'b1111;
            req_a[31:0]    = $urandom;
            req_a[63:32]   = $urandom;
            req_a[127:96]  = $urandom;
            #1;
            chk("bp_resp_valid2", 128'(resp_valid[2]), 128'(1));
            chk("bp_resp_c2", 128'(resp_c[95:64]), 128'(held));
            chk("bp_no_grant2", 128'(req_ready[2]), 128'(0));
            if (req_ready != '0) others++;
            step();
        end
        chk("bp_others_granted", 128'(others > 0), 128'(1));
        drain();

        // Reset asserted the cycle after a grant drops the op.
        req_valid = 4'b0010;
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        m_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) begin
            #1;
            chk("midrst_no_resp", 128'(resp_valid), 128'(0));
            step();
        end
        req_valid = '1;
        #1;
        chk("midrst_grant0", 128'(req_ready), 128'(4'b0001));
        step();
        drain();

        // Inf + -Inf result passes through untouched.
        req_valid = 4'b0010;
        req_a[63:32] = 32'h7f80_0000;
        req_b[63:32] = 32'hff80_0000;
        step();
        req_valid = '0;
        step();
        #1;
        chk("nan_resp_c1", 128'(resp_c[63:32]), 128'(32'h7fff_ffff));
        drain();

        // issue_count wrap.
        req_valid = '0;
        force dut.issue_count = 32'hffff_ffff;
        #1;
        release dut.issue_count;
        m_cnt = 32'hffff_ffff;
        step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        #1;
        chk("wrap_count", 128'(issue_count), 128'(0));
        step();
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid  = N'($urandom);
            resp_ready = N'($urandom) | N'($urandom);
            req_a      = {$urandom, $urandom, $urandom, $urandom};
            req_b      = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
